// File: rtl/ca_code_if.sv
// ca_code_if: DDS phase / PRN control in, C/A code chips out.
// master drives phase, prn, load; slave (ca_code_gen) drives the chip outputs.
interface ca_code_if #(
  parameter int PHASE_WIDTH = 3
);
  logic [PHASE_WIDTH-1:0] phase;
  logic [5:0]             prn;
  logic                   load;
  logic                   early_chip;
  logic                   prompt_chip;
  logic                   late_chip;
  logic [9:0]             chip_count;
  logic                   epoch;
  logic                   code_valid;

  modport master (
    output phase, prn, load,
    input  early_chip, prompt_chip, late_chip,
    input  chip_count, epoch, code_valid
  );

  modport slave (
    input  phase, prn, load,
    output early_chip, prompt_chip, late_chip,
    output chip_count, epoch, code_valid
  );
endinterface

// File: rtl/ca_code_gen.sv
// ca_code_gen: GPS L1 C/A Gold-code generator stepped by the DDS phase MSB.
// Ports: clk, reset (sync, active-high), bus (ca_code_if.slave).
module ca_code_gen #(
  parameter int PHASE_WIDTH = 3,
  parameter int CODE_LEN    = 1023
) (
  input logic     clk,
  input logic     reset,
  ca_code_if.slave bus
);

  localparam logic [9:0] LAST = 10'(CODE_LEN - 1);

  logic       msb_q;
  logic [9:0] g1_q, g1_d;
  logic [9:0] g2_q, g2_d;
  logic [9:0] cnt_q, cnt_d;
  logic [5:0] prn_q, prn_d;
  logic       valid_q, valid_d;
  logic       prompt_q, prompt_d;
  logic       late_q, late_d;
  logic       epoch_q, epoch_d;

  logic       msb;
  logic       chip_tick;
  logic       half_tick;
  logic [3:0] ti, tj;
  logic       g2sel;
  logic       early;
  logic       g1_fb, g2_fb;
  logic       unused_phase;

  assign msb       = bus.phase[PHASE_WIDTH-1];
  assign chip_tick = msb_q & ~msb;
  assign half_tick = ~msb_q & msb;

  assign unused_phase = ^bus.phase[PHASE_WIDTH-2:0];

  // Bit k-1 holds LFSR stage k; shifting moves toward stage 10.
  assign g1_fb = g1_q[2] ^ g1_q[9];
  assign g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[5]
               ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];

  always_comb begin
    ti = 4'd1;
    tj = 4'd1;
    case (prn_q)
      6'd1:  begin ti = 4'd2; tj = 4'd6;  end
      6'd2:  begin ti = 4'd3; tj = 4'd7;  end
      6'd3:  begin ti = 4'd4; tj = 4'd8;  end
      6'd4:  begin ti = 4'd5; tj = 4'd9;  end
      6'd5:  begin ti = 4'd1; tj = 4'd9;  end
      6'd6:  begin ti = 4'd2; tj = 4'd10; end
      6'd7:  begin ti = 4'd1; tj = 4'd8;  end
      6'd8:  begin ti = 4'd2; tj = 4'd9;  end
      6'd9:  begin ti = 4'd3; tj = 4'd10; end
      6'd10: begin ti = 4'd2; tj = 4'd3;  end
      6'd11: begin ti = 4'd3; tj = 4'd4;  end
      6'd12: begin ti = 4'd5; tj = 4'd6;  end
      6'd13: begin ti = 4'd6; tj = 4'd7;  end
      6'd14: begin ti = 4'd7; tj = 4'd8;  end
      6'd15: begin ti = 4'd8; tj = 4'd9;  end
      6'd16: begin ti = 4'd9; tj = 4'd10; end
      6'd17: begin ti = 4'd1; tj = 4'd4;  end
      6'd18: begin ti = 4'd2; tj = 4'd5;  end
      6'd19: begin ti = 4'd3; tj = 4'd6;  end
      6'd20: begin ti = 4'd4; tj = 4'd7;  end
      6'd21: begin ti = 4'd5; tj = 4'd8;  end
      6'd22: begin ti = 4'd6; tj = 4'd9;  end
      6'd23: begin ti = 4'd1; tj = 4'd3;  end
      6'd24: begin ti = 4'd4; tj = 4'd6;  end
      6'd25: begin ti = 4'd5; tj = 4'd7;  end
      6'd26: begin ti = 4'd6; tj = 4'd8;  end
      6'd27: begin ti = 4'd7; tj = 4'd9;  end
      6'd28: begin ti = 4'd8; tj = 4'd10; end
      6'd29: begin ti = 4'd1; tj = 4'd6;  end
      6'd30: begin ti = 4'd2; tj = 4'd7;  end
      6'd31: begin ti = 4'd3; tj = 4'd8;  end
      6'd32: begin ti = 4'd4; tj = 4'd9;  end
      default: begin ti = 4'd1; tj = 4'd1; end
    endcase
  end

  // Equal default taps cancel, so an invalid PRN yields 0 here too.
  assign g2sel = g2_q[ti - 4'd1] ^ g2_q[tj - 4'd1];
  assign early = valid_q & (g1_q[9] ^ g2sel);

  always_comb begin
    g1_d     = g1_q;
    g2_d     = g2_q;
    cnt_d    = cnt_q;
    prn_d    = prn_q;
    valid_d  = valid_q;
    prompt_d = prompt_q;
    late_d   = late_q;
    epoch_d  = 1'b0;
    if (bus.load) begin
      prn_d    = bus.prn;
      valid_d  = (bus.prn >= 6'd1) && (bus.prn <= 6'd32);
      g1_d     = '1;
      g2_d     = '1;
      cnt_d    = '0;
      prompt_d = 1'b0;
      late_d   = 1'b0;
    end else if (valid_q) begin
      if (chip_tick) begin
        late_d = prompt_q;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          g1_d    = '1;
          g2_d    = '1;
          epoch_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
          g1_d  = {g1_q[8:0], g1_fb};
          g2_d  = {g2_q[8:0], g2_fb};
        end
      end else if (half_tick) begin
        prompt_d = early;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msb_q    <= 1'b0;
      g1_q     <= '1;
      g2_q     <= '1;
      cnt_q    <= '0;
      prn_q    <= '0;
      valid_q  <= 1'b0;
      prompt_q <= 1'b0;
      late_q   <= 1'b0;
      epoch_q  <= 1'b0;
    end else begin
      msb_q    <= msb;
      g1_q     <= g1_d;
      g2_q     <= g2_d;
      cnt_q    <= cnt_d;
      prn_q    <= prn_d;
      valid_q  <= valid_d;
      prompt_q <= prompt_d;
      late_q   <= late_d;
      epoch_q  <= epoch_d;
    end
  end

  assign bus.early_chip  = early;
  assign bus.prompt_chip = prompt_q;
  assign bus.late_chip   = late_q;
  assign bus.chip_count  = cnt_q;
  assign bus.epoch       = epoch_q;
  assign bus.code_valid  = valid_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// tb_ca_code_gen: scoreboard bench for ca_code_gen.
// A golden Gold-code table plus a chip-level model feed an expected-output queue.
module tb_ca_code_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ca_code_if #(.PHASE_WIDTH(3)) bus ();

  ca_code_gen #(.PHASE_WIDTH(3), .CODE_LEN(1023)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int t1[1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,
                   1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int t2[1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,
                   4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
  bit code_tab[1:32][0:1022];

  task automatic build_tab();
    int a[1:10];
    int b[1:10];
    int fa, fb;
    for (int p = 1; p <= 32; p++) begin
      for (int k = 1; k <= 10; k++) begin
        a[k] = 1;
        b[k] = 1;
      end
      for (int i = 0; i < 1023; i++) begin
        code_tab[p][i] = bit'(a[10] ^ b[t1[p]] ^ b[t2[p]]);
        fa = a[3] ^ a[10];
        fb = b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10];
        for (int k = 10; k >= 2; k--) begin
          a[k] = a[k-1];
          b[k] = b[k-1];
        end
        a[1] = fa;
        b[1] = fb;
      end
    end
  endtask

  // chip-level reference state
  bit m_valid, m_epoch, m_prompt, m_late, m_msb;
  int m_idx, m_prn;

  logic [14:0] sb_q[$];
  int          ep_cnt;
  logic [9:0]  cap;
  int          ph_cur;

  function automatic bit m_early();
    if (m_valid) return code_tab[m_prn][m_idx];
    return 1'b0;
  endfunction

  task automatic step(input logic rst, input logic ld,
                      input logic [5:0] p, input logic [2:0] ph);
    bit e, ct, ht;
    logic [14:0] got;
    if (errs >= 200) return;
    reset     = rst;
    bus.load  = ld;
    bus.prn   = p;
    bus.phase = ph;
    e  = m_early();
    ct = m_msb & ~ph[2];
    ht = ~m_msb & ph[2];
    if (rst) begin
      m_valid = 0; m_epoch = 0; m_prompt = 0; m_late = 0;
      m_idx = 0; m_prn = 0;
    end else if (ld) begin
      m_prn    = int'(p);
      m_valid  = (p >= 1) && (p <= 32);
      m_idx    = 0;
      m_prompt = 0;
      m_late   = 0;
      m_epoch  = 0;
    end else if (m_valid) begin
      m_epoch = 0;
      if (ct) begin
        m_late = m_prompt;
        if (m_idx == 1022) begin
          m_idx   = 0;
          m_epoch = 1;
        end else begin
          m_idx++;
        end
      end
      if (ht) m_prompt = e;
    end
    m_msb = rst ? 1'b0 : ph[2];
    sb_q.push_back({m_valid, m_epoch, m_early(), m_prompt, m_late,
                    10'(m_idx)});
    @(posedge clk);
    #1;
    got = {bus.code_valid, bus.epoch, bus.early_chip, bus.prompt_chip,
           bus.late_chip, bus.chip_count};
    check("out", 32'(got), 32'(sb_q.pop_front()));
    if (bus.epoch) ep_cnt++;
    if (bus.code_valid && bus.chip_count < 10)
      cap[9 - bus.chip_count] = bus.early_chip;
  endtask

  task automatic run(input int n, input int inc);
    for (int i = 0; i < n; i++) begin
      ph_cur = (ph_cur + inc) % 8;
      step(1'b0, 1'b0, 6'd0, 3'(ph_cur));
    end
  endtask

  task automatic load(input logic [5:0] p);
    step(1'b0, 1'b1, p, 3'(ph_cur));
  endtask

  initial begin
    build_tab();
    ph_cur = 0;
    ep_cnt = 0;
    cap    = '0;
    bus.load  = 1'b0;
    bus.prn   = '0;
    bus.phase = '0;
    reset     = 1'b1;

    repeat (3) step(1'b1, 1'b0, 6'd0, 3'd0);
    check("rst_valid", 32'(bus.code_valid), 32'd0);
    check("rst_cnt", 32'(bus.chip_count), 32'd0);

    load(6'd1);
    cap = '0;
    run(96, 1);
    check("prn1_oct", 32'(cap), 32'(10'o1440));

    load(6'd2);
    cap = '0;
    run(96, 1);
    check("prn2_oct", 32'(cap), 32'(10'o1620));

    // load coinciding with a chip tick
    run(7, 1);
    ph_cur = 0;
    load(6'd2);
    check("ld_tick_cnt", 32'(bus.chip_count), 32'd0);
    check("ld_tick_early", 32'(bus.early_chip), 32'(code_tab[2][0]));
    run(30, 1);

    // reset mid-code
    ph_cur = (ph_cur + 1) % 8;
    step(1'b1, 1'b0, 6'd0, 3'(ph_cur));
    check("mid_rst_valid", 32'(bus.code_valid), 32'd0);
    check("mid_rst_early", 32'(bus.early_chip), 32'd0);
    run(20, 1);
    check("post_rst_cnt", 32'(bus.chip_count), 32'd0);

    // out-of-range PRNs
    ep_cnt = 0;
    load(6'd0);
    run(1000, 4);
    load(6'd40);
    run(1000, 4);
    check("inv_epoch", 32'(ep_cnt), 32'd0);
    check("inv_valid", 32'(bus.code_valid), 32'd0);

    // full period for every PRN
    for (int p = 1; p <= 32; p++) begin
      load(6'(p));
      ep_cnt = 0;
      cap    = '0;
      run(2 * 1023 + 20, 4);
      check("epoch_cnt", 32'(ep_cnt), 32'd1);
      if (p == 1) check("prn1_wrap_oct", 32'(cap), 32'(10'o1440));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
